alu_issue_seq: RTL and testbench

ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

---
 rtl/alu_issue_seq.sv | 210 +++++++++++++++++++++
 tb/tb_alu_issue_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: command FIFO feeding a downstream ALU through a four-state
// issue sequencer (IDLE -> ISSUE -> WAIT -> HOLD), with a valid/ready result port.
// Optional feature: define ALU_ISSUE_SEQ_CMP_EN to capture the ALU compare
// flags {G,L,E} onto out_gle; otherwise out_gle is tied to zero.
module alu_issue_seq #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [3:0] in_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_f,
  input  logic [2:0] alu_zco,
  input  logic [2:0] alu_gle,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_f,
  output logic [2:0] out_zco,
  output logic [2:0] out_gle,
  output logic       busy,
  output logic [7:0] op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [19:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      opa_q, opb_q;
  logic [3:0]      opc_q;
  logic            out_valid_q;
  logic [7:0]      out_f_q;
  logic [2:0]      out_zco_q;
  logic [7:0]      op_count_q;

  logic            push_s;
  logic            pop_s;
  logic            cap_flags_s;
  logic            cap_f_s;
  logic            retire_s;
  logic            in_ready_s;
  logic [19:0]     head_s;

  // Full means no push, regardless of a same-cycle pop; reset also blocks pushes.
  assign in_ready_s = (count_q < CW'(DEPTH)) && rst;
  assign push_s     = in_valid && in_ready_s;
  assign head_s     = mem_q[rd_ptr_q];

  assign in_ready  = in_ready_s;
  assign alu_a     = opa_q;
  assign alu_b     = opb_q;
  assign alu_op    = opc_q;
  assign out_valid = out_valid_q;
  assign out_f     = out_f_q;
  assign out_zco   = out_zco_q;
  assign busy      = (state_q != ST_IDLE);
  assign op_count  = op_count_q;

  // Next-state and per-state strobes; pops only ever happen with a non-empty FIFO.
  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    cap_flags_s = 1'b0;
    cap_f_s     = 1'b0;
    retire_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != CW'(0)) begin
          pop_s   = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cap_flags_s = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        cap_f_s = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          retire_s = 1'b1;
          if (count_q != CW'(0)) begin
            pop_s   = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_op, in_b, in_a};
    end
  end

  // FIFO pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Operand registers: loaded on pop, otherwise hold to keep the ALU inputs steady.
  always_ff @(posedge clk) begin
    if (!rst) begin
      opa_q <= 8'h00;
      opb_q <= 8'h00;
      opc_q <= 4'h0;
    end else if (pop_s) begin
      opa_q <= head_s[7:0];
      opb_q <= head_s[15:8];
      opc_q <= head_s[19:16];
    end
  end

  // Result capture: flags at the end of ISSUE, F at the end of WAIT, retire on out_ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_f_q     <= 8'h00;
      out_zco_q   <= 3'b000;
      op_count_q  <= 8'h00;
    end else begin
      if (cap_flags_s) begin
        out_zco_q <= alu_zco;
      end
      if (cap_f_s) begin
        out_f_q     <= alu_f;
        out_valid_q <= 1'b1;
      end else if (retire_s) begin
        out_valid_q <= 1'b0;
      end
      if (retire_s) begin
        op_count_q <= op_count_q + 8'd1;
      end
    end
  end

`ifdef ALU_ISSUE_SEQ_CMP_EN
  logic [2:0] out_gle_q;

  // Compare flags are captured alongside {z,c,o} at the end of ISSUE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_gle_q <= 3'b000;
    end else if (cap_flags_s) begin
      out_gle_q <= alu_gle;
    end
  end

  assign out_gle = out_gle_q;
`else
  // Compare path disabled: alu_gle is intentionally ignored.
  logic unused_gle_s;
  assign unused_gle_s = ^alu_gle;
  assign out_gle      = 3'b000;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed self-checking bench for alu_issue_seq (DEPTH = 4).
// The bench models the downstream ALU as an adder: registered F = A + B,
// combinational {z,c,o} from the same sum, and a bench-driven {G,L,E}.
module tb_alu_issue_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] in_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_f;
  logic [2:0] alu_zco;
  logic [2:0] alu_gle;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_f;
  logic [2:0] out_zco;
  logic [2:0] out_gle;
  logic       busy;
  logic [7:0] op_count;

  int nchecks;
  int nerr;
  int wait_n;

`ifdef ALU_ISSUE_SEQ_CMP_EN
  localparam logic [2:0] GLE_EXP = 3'b100;
`else
  localparam logic [2:0] GLE_EXP = 3'b000;
`endif

  alu_issue_seq #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_op    (in_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_f    (alu_f),
    .alu_zco  (alu_zco),
    .alu_gle  (alu_gle),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_f    (out_f),
    .out_zco  (out_zco),
    .out_gle  (out_gle),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: registered sum, combinational flags.
  logic [8:0] sum9_s;
  always_comb begin
    sum9_s  = {1'b0, alu_a} + {1'b0, alu_b};
    alu_zco = {(sum9_s[7:0] == 8'h00), sum9_s[8],
               (alu_a[7] == alu_b[7]) && (sum9_s[7] != alu_a[7])};
  end

  always_ff @(posedge clk) begin
    alu_f <= alu_a + alu_b;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance until out_valid is seen or the budget runs out; returns cycles waited.
  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  initial begin
    nchecks   = 0;
    nerr      = 0;
    rst       = 1'b0;
    out_ready = 1'b0;
    alu_gle   = 3'b100;
    drive(1'b0, 8'h00, 8'h00, 4'h0);
    tick();
    tick();

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_op_count", {24'd0, op_count}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_out_f", {24'd0, out_f}, 32'd0);
    chk("rst_out_gle", {29'd0, out_gle}, 32'd0);
    chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);

    // Release reset; first push on the very next edge
    rst = 1'b1;
    #1;
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 8'h12, 8'h34, 4'h3);
    tick();                                   // edge 0: accepted
    drive(1'b0, 8'h00, 8'h00, 4'h0);
    chk("t1_idle_after_push", {31'd0, busy}, 32'd0);
    tick();                                   // edge 1: popped to operands
    chk("t1_alu_a", {24'd0, alu_a}, 32'h12);
    chk("t1_alu_b", {24'd0, alu_b}, 32'h34);
    chk("t1_alu_op", {28'd0, alu_op}, 32'h3);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    tick();                                   // edge 2: flags captured
    chk("t1_no_valid_e2", {31'd0, out_valid}, 32'd0);
    tick();                                   // edge 3: result valid
    chk("t1_valid_e3", {31'd0, out_valid}, 32'd1);
    chk("t1_out_f", {24'd0, out_f}, 32'h46);
    chk("t1_out_zco", {29'd0, out_zco}, 32'b000);
    chk("t1_out_gle", {29'd0, out_gle}, {29'd0, GLE_EXP});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_retired_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_op_count", {24'd0, op_count}, 32'd1);
    chk("t1_back_idle", {31'd0, busy}, 32'd0);

    // Fill: five back-to-back pushes, first one moves into HOLD
    drive(1'b1, 8'hFF, 8'h01, 4'h1); tick();
    drive(1'b1, 8'h7F, 8'h01, 4'h2); tick();
    drive(1'b1, 8'h10, 8'h20, 4'h4); tick();
    drive(1'b1, 8'h80, 8'h80, 4'h5); tick();
    chk("fill_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("fill_in_ready_3", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 8'h01, 8'h02, 4'h6); tick();
    chk("full_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("full_count4", {28'd0, 4'(dut.count_q)}, 32'd4);
    drive(1'b1, 8'hAA, 8'h55, 4'h7);        // rejected while full

    // Stay in HOLD for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_out_f", {24'd0, out_f}, 32'h00);
      chk("hold_out_zco", {29'd0, out_zco}, 32'b110);
      chk("hold_busy", {31'd0, busy}, 32'd1);
    end
    chk("hold_no_pop_count", {28'd0, 4'(dut.count_q)}, 32'd4);
    chk("hold_no_pop_alu_a", {24'd0, alu_a}, 32'hFF);

    // Full + in_valid + pop in the same cycle: pop only
    out_ready = 1'b1;
    tick();
    chk("fullpop_count3", {28'd0, 4'(dut.count_q)}, 32'd3);
    chk("fullpop_op_count", {24'd0, op_count}, 32'd2);
    chk("fullpop_alu_a", {24'd0, alu_a}, 32'h7F);
    chk("fullpop_in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b0, 8'h00, 8'h00, 4'h0);

    // Drain in push order, one result every 3 cycles
    wait_valid("wait_r2", 8, wait_n);
    chk("r2_latency", wait_n, 32'd2);
    chk("r2_out_f", {24'd0, out_f}, 32'h80);
    chk("r2_out_zco", {29'd0, out_zco}, 32'b001);
    tick();
    wait_valid("wait_r3", 8, wait_n);
    chk("r3_spacing", wait_n, 32'd2);
    chk("r3_out_f", {24'd0, out_f}, 32'h30);
    chk("r3_out_zco", {29'd0, out_zco}, 32'b000);
    tick();
    wait_valid("wait_r4", 8, wait_n);
    chk("r4_spacing", wait_n, 32'd2);
    chk("r4_out_f", {24'd0, out_f}, 32'h00);
    chk("r4_out_zco", {29'd0, out_zco}, 32'b111);
    tick();
    wait_valid("wait_r5", 8, wait_n);
    chk("r5_spacing", wait_n, 32'd2);
    chk("r5_out_f", {24'd0, out_f}, 32'h03);
    tick();
    chk("drain_op_count", {24'd0, op_count}, 32'd6);
    chk("drain_idle", {31'd0, busy}, 32'd0);
    chk("drain_valid_low", {31'd0, out_valid}, 32'd0);

    // Reset during WAIT with two commands queued
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 8'h11, 4'h1); tick();
    drive(1'b1, 8'h22, 8'h22, 4'h2); tick();
    drive(1'b1, 8'h33, 8'h33, 4'h3); tick();
    chk("mid_count2", {28'd0, 4'(dut.count_q)}, 32'd2);
    drive(1'b0, 8'h00, 8'h00, 4'h0);
    rst = 1'b0;
    tick();
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_count", {28'd0, 4'(dut.count_q)}, 32'd0);
    chk("mid_rst_op_count", {24'd0, op_count}, 32'd0);
    chk("mid_rst_alu_a", {24'd0, alu_a}, 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end

    // 256 operations wrap op_count back to zero
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 8'(i), 8'h01, 4'h3);
      tick();
      drive(1'b0, 8'h00, 8'h00, 4'h0);
      wait_valid("wrap_wait", 10, wait_n);
      if (i == 255) begin
        chk("wrap_last_out_f", {24'd0, out_f}, 32'h00);
        chk("wrap_last_out_gle", {29'd0, out_gle}, {29'd0, GLE_EXP});
        chk("wrap_op_count_255", {24'd0, op_count}, 32'd255);
      end
      tick();
    end
    chk("wrap_op_count_0", {24'd0, op_count}, 32'd0);
    chk("wrap_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
